// File: rtl/cmos_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cmos_wr_arbiter
//  Purpose  : Round-robin scheduler sharing one burst write port between two
//             camera capture FIFOs, each stream in its own frame region.
//  Revision : 1.0  initial release
// ============================================================================
module cmos_wr_arbiter #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 22,
    parameter int                CNT_W       = 10,
    parameter int                BURST_LEN   = 256,
    parameter int                FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BASE0       = '0,
    parameter logic [ADDR_W-1:0] BASE1       = 22'h100000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CNT_W-1:0]  cmos0_fifo_cnt,
    input  logic [DATA_W-1:0] cmos0_fifo_dout,
    output logic              cmos0_fifo_rd,
    input  logic              cmos0_frame_start,
    input  logic [CNT_W-1:0]  cmos1_fifo_cnt,
    input  logic [DATA_W-1:0] cmos1_fifo_dout,
    output logic              cmos1_fifo_rd,
    input  logic              cmos1_frame_start,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    output logic              grant,
    output logic              busy
);

    localparam int                  c_off_w     = $clog2(FRAME_WORDS);
    localparam int                  c_beat_w    = $clog2(BURST_LEN);
    localparam logic [CNT_W:0]      c_burst_cnt = (CNT_W+1)'(BURST_LEN);
    localparam logic [c_off_w:0]    c_burst_off = (c_off_w+1)'(BURST_LEN);
    localparam logic [c_off_w:0]    c_frame_off = (c_off_w+1)'(FRAME_WORDS);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BURST_LEN-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_beat_w-1:0] r_beat;
    logic [c_off_w-1:0]  r_off [2];
    logic [1:0]          r_pend;

    logic [1:0]          w_elig;
    logic [1:0]          w_fs;
    logic [1:0]          w_own;
    logic [1:0]          w_apply;
    logic [c_off_w:0]    w_off_sum [2];
    logic [c_off_w-1:0]  w_off_inc [2];
    logic [c_off_w-1:0]  w_off_eff [2];
    logic                w_pick;
    logic [ADDR_W-1:0]   w_addr_nxt;

    assign w_elig = {({1'b0, cmos1_fifo_cnt} >= c_burst_cnt),
                     ({1'b0, cmos0_fifo_cnt} >= c_burst_cnt)};
    assign w_fs   = {cmos1_frame_start, cmos0_frame_start};
    assign w_pick = (&w_elig) ? ~r_last : w_elig[1];

    // A camera owns its burst from REQ through DONE, so a frame start seen
    // while it is queued is deferred and lands as a clear in DONE.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_own[n]     = (r_state != S_IDLE) && (r_grant == n[0]);
            w_apply[n]   = r_pend[n] && (!w_own[n] || (r_state == S_DONE));
            w_off_sum[n] = {1'b0, r_off[n]} + c_burst_off;
            w_off_inc[n] = (w_off_sum[n] >= c_frame_off) ? '0 : w_off_sum[n][c_off_w-1:0];
            w_off_eff[n] = w_apply[n] ? '0 : r_off[n];
        end
    end

    assign w_addr_nxt = w_pick ? (BASE1 + ADDR_W'(w_off_eff[1]))
                               : (BASE0 + ADDR_W'(w_off_eff[0]));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        wr_req        = 1'b0;
        busy          = 1'b0;
        cmos0_fifo_rd = 1'b0;
        cmos1_fifo_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                busy   = 1'b1;
                wr_req = 1'b1;
                if (wr_ack) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                busy          = 1'b1;
                cmos0_fifo_rd = wr_data_req & ~r_grant;
                cmos1_fifo_rd = wr_data_req &  r_grant;
                if (wr_data_req && (r_beat == c_last_beat)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_beat   <= '0;
            r_off[0] <= '0;
            r_off[1] <= '0;
            r_pend   <= '0;
        end else begin
            if ((r_state == S_IDLE) && (|w_elig)) begin
                r_grant <= w_pick;
                r_addr  <= w_addr_nxt;
            end
            if ((r_state == S_REQ) && wr_ack)
                r_beat <= '0;
            else if ((r_state == S_DATA) && wr_data_req)
                r_beat <= r_beat + 1'b1;
            if (r_state == S_DONE) r_last <= r_grant;
            for (int n = 0; n < 2; n++) begin
                if (w_apply[n])
                    r_off[n] <= '0;
                else if ((r_state == S_DONE) && w_own[n])
                    r_off[n] <= w_off_inc[n];
                if (w_fs[n])         r_pend[n] <= 1'b1;
                else if (w_apply[n]) r_pend[n] <= 1'b0;
            end
        end
    end

    assign wr_addr = r_addr;
    assign grant   = r_grant;
    assign wr_data = r_grant ? cmos1_fifo_dout : cmos0_fifo_dout;

endmodule
`default_nettype wire

// File: tb/tb_cmos_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmos_wr_arbiter
//  Purpose  : Scoreboard bench for cmos_wr_arbiter (4-burst frame region).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmos_wr_arbiter;

    localparam int          c_burst = 256;
    localparam int          c_frame = 1024;
    localparam logic [21:0] c_base1 = 22'h100000;
    localparam logic [15:0] c_dout0 = 16'hC0C0;
    localparam logic [15:0] c_dout1 = 16'h1C1C;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  cmos0_fifo_cnt = '0;
    logic [15:0] cmos0_fifo_dout = c_dout0;
    logic        cmos0_fifo_rd;
    logic        cmos0_frame_start = 1'b0;
    logic [9:0]  cmos1_fifo_cnt = '0;
    logic [15:0] cmos1_fifo_dout = c_dout1;
    logic        cmos1_fifo_rd;
    logic        cmos1_frame_start = 1'b0;
    logic        wr_req;
    logic [21:0] wr_addr;
    logic        wr_ack = 1'b0;
    logic        wr_data_req = 1'b0;
    logic [15:0] wr_data;
    logic        grant;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    cmos_wr_arbiter #(.FRAME_WORDS(c_frame)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .cmos0_fifo_cnt   (cmos0_fifo_cnt),
        .cmos0_fifo_dout  (cmos0_fifo_dout),
        .cmos0_fifo_rd    (cmos0_fifo_rd),
        .cmos0_frame_start(cmos0_frame_start),
        .cmos1_fifo_cnt   (cmos1_fifo_cnt),
        .cmos1_fifo_dout  (cmos1_fifo_dout),
        .cmos1_fifo_rd    (cmos1_fifo_rd),
        .cmos1_frame_start(cmos1_frame_start),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_ack           (wr_ack),
        .wr_data_req      (wr_data_req),
        .wr_data          (wr_data),
        .grant            (grant),
        .busy             (busy)
    );

    typedef struct {
        logic        g;
        logic [21:0] a;
        int          reqc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stray = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic g, input logic [21:0] a, input int rc);
        exp_t e;
        e.g = g;
        e.a = a;
        e.reqc = rc;
        q.push_back(e);
    endtask

    // Monitor: one window per burst, from the first wr_req cycle until busy drops.
    logic        m_in = 1'b0;
    logic        m_g;
    logic [21:0] m_a;
    int          m_rd0, m_rd1, m_reqc, m_dbad, m_aunst;
    exp_t        m_e;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            m_in = 1'b0;
        end else begin
            if (wr_req) begin
                if (!m_in) begin
                    m_in = 1'b1; m_g = grant; m_a = wr_addr;
                    m_rd0 = 0; m_rd1 = 0; m_reqc = 0; m_dbad = 0; m_aunst = 0;
                end
                m_reqc++;
                if (wr_addr !== m_a) m_aunst++;
            end
            if (m_in) begin
                if (cmos0_fifo_rd) begin
                    m_rd0++;
                    if (!m_g && wr_data !== c_dout0) m_dbad++;
                end
                if (cmos1_fifo_rd) begin
                    m_rd1++;
                    if (m_g && wr_data !== c_dout1) m_dbad++;
                end
                if (!busy) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_burst: got grant %0d addr %0h, expected none", m_g, m_a);
                    end else begin
                        m_e = q.pop_front();
                        check("grant",       32'(m_g), 32'(m_e.g));
                        check("addr",        32'(m_a), 32'(m_e.a));
                        check("rd_granted",  m_e.g ? m_rd1 : m_rd0, c_burst);
                        check("rd_other",    m_e.g ? m_rd0 : m_rd1, 0);
                        check("req_cycles",  m_reqc, m_e.reqc);
                        check("data_mux",    m_dbad, 0);
                        check("addr_stable", m_aunst, 0);
                    end
                    m_in = 1'b0;
                end
            end else if (cmos0_fifo_rd || cmos1_fifo_rd) begin
                stray++;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_wr_req",  32'(wr_req), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_grant",   32'(grant), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_rd0",     32'(cmos0_fifo_rd), 0);
        check("rst_rd1",     32'(cmos1_fifo_rd), 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cmos0_fifo_cnt = '0;
        cmos1_fifo_cnt = '0;
        wr_ack = 1'b0;
        wr_data_req = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    // Controller model: serves one burst. fs_beat / abort_beat < 0 disable those events.
    task automatic do_burst(input int ack_dly, input bit throttle, input int extra,
                            input bit clr, input int fs_beat, input int abort_beat);
        int t = 0;
        int taken = 0;
        bit ph = 1'b1;
        bit fs_done = 1'b0;
        while (!wr_req && t < 1000) begin
            @(posedge sys_clk); #1;
            t++;
        end
        check("req_seen", 32'(wr_req), 1);
        if (!wr_req) return;
        repeat (ack_dly) begin @(posedge sys_clk); #1; end
        wr_ack = 1'b1;
        @(posedge sys_clk); #1;
        wr_ack = 1'b0;
        while (taken < c_burst) begin
            if (abort_beat >= 0 && taken == abort_beat) begin
                wr_data_req = 1'b1;
                sys_rst_n = 1'b0;
                #1;
                check_reset_outputs();
                repeat (2) @(posedge sys_clk);
                #1;
                wr_data_req = 1'b0;
                sys_rst_n = 1'b1;
                return;
            end
            wr_data_req = throttle ? ph : 1'b1;
            ph = ~ph;
            cmos0_frame_start = (taken == fs_beat) && !fs_done;
            if (cmos0_frame_start) fs_done = 1'b1;
            if (wr_data_req && taken == c_burst - 1 && clr) begin
                cmos0_fifo_cnt = '0;
                cmos1_fifo_cnt = '0;
            end
            if (wr_data_req) taken++;
            @(posedge sys_clk); #1;
        end
        wr_data_req = 1'b0;
        cmos0_frame_start = 1'b0;
        repeat (extra) begin
            wr_data_req = 1'b1;
            @(posedge sys_clk); #1;
        end
        wr_data_req = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (10) @(posedge sys_clk);
        #1;
        check({name, "_drained"}, q.size(), 0);
        check({name, "_stray"}, stray, 0);
    endtask

    initial begin
        // Reset values, with eligible FIFOs and a pending data request.
        sys_rst_n = 1'b0;
        cmos0_fifo_cnt = 10'd300;
        cmos1_fifo_cnt = 10'd300;
        wr_data_req = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs();
        do_reset();

        // Single camera
        cmos0_fifo_cnt = 10'd256;
        push(1'b0, 22'd0, 1);
        push(1'b0, 22'd256, 1);
        do_burst(0, 1'b0, 0, 1'b0, -1, -1);
        do_burst(0, 1'b0, 0, 1'b1, -1, -1);
        settle("single");

        // Round-robin
        do_reset();
        cmos0_fifo_cnt = 10'd300;
        cmos1_fifo_cnt = 10'd300;
        push(1'b0, 22'd0, 1);
        push(1'b1, c_base1, 1);
        push(1'b0, 22'd256, 1);
        push(1'b1, c_base1 + 22'd256, 1);
        for (int i = 0; i < 4; i++) do_burst(0, 1'b0, 0, i == 3, -1, -1);
        settle("rr");

        // Wrap-around of the cmos1 region (4 bursts per frame here)
        do_reset();
        cmos1_fifo_cnt = 10'd256;
        for (int i = 0; i < 9; i++) push(1'b1, c_base1 + 22'((i % 4) * c_burst), 1);
        for (int i = 0; i < 9; i++) do_burst(0, 1'b0, 0, i == 8, -1, -1);
        settle("wrap");

        // Frame start during the burst at offset 512
        do_reset();
        cmos0_fifo_cnt = 10'd256;
        push(1'b0, 22'd0, 1);
        push(1'b0, 22'd256, 1);
        push(1'b0, 22'd512, 1);
        push(1'b0, 22'd0, 1);
        do_burst(0, 1'b0, 0, 1'b0, -1, -1);
        do_burst(0, 1'b0, 0, 1'b0, -1, -1);
        do_burst(0, 1'b0, 0, 1'b0, 10, -1);
        do_burst(0, 1'b0, 0, 1'b1, -1, -1);
        settle("fstart");

        // Throttled handshake with trailing requests
        do_reset();
        cmos0_fifo_cnt = 10'd256;
        push(1'b0, 22'd0, 5);
        do_burst(4, 1'b1, 3, 1'b1, -1, -1);
        settle("throttle");

        // Reset during a cmos1 burst
        do_reset();
        cmos0_fifo_cnt = 10'd300;
        cmos1_fifo_cnt = 10'd300;
        push(1'b0, 22'd0, 1);
        do_burst(0, 1'b0, 0, 1'b0, -1, -1);
        do_burst(0, 1'b0, 0, 1'b0, -1, 100);
        push(1'b0, 22'd0, 1);
        do_burst(0, 1'b0, 0, 1'b1, -1, -1);
        settle("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected bursts outstanding", q.size());
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
